// File: rtl/lgn_pixel_packer_if.sv
// Pixel stream between the grayscale source and the LGN pixel packer.
// The source drives valid/data/last and the packer answers with ready.
interface lgn_pixel_packer_if #(
   parameter int PIX_W = 8
);
   logic             pix_valid;
   logic             pix_ready;
   logic [PIX_W-1:0] pix_data;
   logic             pix_last;

   modport master (
      output pix_valid,
      output pix_data,
      output pix_last,
      input  pix_ready
   );

   modport slave (
      input  pix_valid,
      input  pix_data,
      input  pix_last,
      output pix_ready
   );
endinterface

// File: rtl/lgn_pixel_packer.sv
// LGN front end: binarizes a 28x28 grayscale frame, packs 8 pixels per byte MSB first
// and frames the image. Define LGN_PACKER_STATS_EN to build the per-frame '1'-pixel counter.
module lgn_pixel_packer #(
   parameter int PIXELS = 784,
   parameter int PIX_W  = 8,
   parameter int CNT_W  = 10
) (
   input  logic             clk,
   input  logic             rst,
   lgn_pixel_packer_if.slave pix,
   input  logic [PIX_W-1:0] threshold,
   output logic             byte_valid,
   output logic [7:0]       byte_data,
   output logic             frame_done,
   output logic             frame_error,
   output logic             busy,
   output logic [CNT_W-1:0] ones_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PACK = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             pix_bit;
   logic             is_last_idx;
   logic             abort;
   logic             finish;
   logic [CNT_W-1:0] pix_idx;
   logic [CNT_W-1:0] pix_cnt;
   logic [PIX_W-1:0] thr_q;
   logic [PIX_W-1:0] thr_eff;
   logic [6:0]       sr;

   assign pix.pix_ready = !rst && (state != DONE);
   assign frame_done    = (state == DONE);
   assign busy          = (state == PACK);

   // The first pixel of a frame uses the live threshold because thr_q is only loaded on that accept.
   always_comb begin
      accept      = pix.pix_valid && pix.pix_ready;
      pix_idx     = (state == IDLE) ? '0 : pix_cnt;
      thr_eff     = (state == IDLE) ? threshold : thr_q;
      pix_bit     = (pix.pix_data >= thr_eff);
      is_last_idx = (pix_idx == LAST_IDX);
      abort       = accept && pix.pix_last && !is_last_idx;
      finish      = accept && is_last_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && !abort) begin
               state_nxt = finish ? DONE : PACK;
            end
         end
         PACK: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (finish) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // An aborted frame suppresses the byte that would otherwise complete on the pix_last pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt     <= '0;
         thr_q       <= '0;
         sr          <= '0;
         byte_valid  <= 1'b0;
         byte_data   <= '0;
         frame_error <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (accept) begin
            sr      <= {sr[5:0], pix_bit};
            pix_cnt <= pix_idx + 1'b1;
            if (state == IDLE) begin
               thr_q <= threshold;
            end
            if ((pix_idx[2:0] == 3'd7) && !abort) begin
               byte_valid <= 1'b1;
               byte_data  <= {sr, pix_bit};
            end
         end
         if (abort || (finish && !pix.pix_last)) begin
            frame_error <= 1'b1;
         end else if (accept && (state == IDLE)) begin
            frame_error <= 1'b0;
         end
      end
   end

`ifdef LGN_PACKER_STATS_EN
   logic [CNT_W-1:0] ones_acc;
   logic [CNT_W-1:0] ones_q;
   logic [CNT_W-1:0] ones_sum;

   assign ones_sum   = ((state == IDLE) ? '0 : ones_acc) + CNT_W'(pix_bit);
   assign ones_count = ones_q;

   // The result is published on the last pixel's accept so it is visible alongside frame_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         ones_acc <= '0;
         ones_q   <= '0;
      end else if (accept) begin
         ones_acc <= ones_sum;
         if (finish) begin
            ones_q <= ones_sum;
         end
      end
   end
`else
   assign ones_count = '0;
`endif

endmodule

// File: tb/tb_lgn_pixel_packer.sv
// Directed bench for lgn_pixel_packer: reset, full frames, gaps, threshold boundary,
// early pix_last abort and mid-frame reset.
module tb_lgn_pixel_packer;

   localparam int PIXELS = 784;
   localparam int NBYTES = PIXELS / 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] threshold;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       frame_done;
   logic       frame_error;
   logic       busy;
   logic [9:0] ones_count;

   int nChecks = 0;
   int nFails  = 0;

   logic [7:0] got[$];
   int ncyc         = 0;
   int doneCnt      = 0;
   int doneWithByte = 0;
   int bytesAtDone  = 0;
   int errAtDone    = 0;
   int onesAtDone   = 0;
   int firstByteNeg = -1;
   int acc7Neg      = -1;
   int accIdx       = 0;
   int multiHigh    = 0;
   int busyMid      = 0;
   int prevBv       = 0;

   lgn_pixel_packer_if #(.PIX_W(8)) pif ();

   lgn_pixel_packer #(
      .PIXELS (PIXELS),
      .PIX_W  (8),
      .CNT_W  (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix         (pif.slave),
      .threshold   (threshold),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .frame_done  (frame_done),
      .frame_error (frame_error),
      .busy        (busy),
      .ones_count  (ones_count)
   );

   always #5 clk = ~clk;

   // Observe outputs and upcoming accepts on the falling edge, away from the active edge.
   always @(negedge clk) begin
      ncyc++;
      if (byte_valid) begin
         got.push_back(byte_data);
         if (firstByteNeg < 0) firstByteNeg = ncyc;
         if (prevBv != 0) multiHigh++;
      end
      prevBv = byte_valid ? 1 : 0;
      if (frame_done) begin
         doneCnt++;
         doneWithByte = byte_valid ? 1 : 0;
         bytesAtDone  = got.size();
         errAtDone    = frame_error ? 1 : 0;
         onesAtDone   = int'(ones_count);
      end
      if (pif.pix_valid && pif.pix_ready && !rst) begin
         if (accIdx == 7) begin
            acc7Neg = ncyc;
            busyMid = busy ? 1 : 0;
         end
         accIdx++;
      end
   end

   function automatic logic [7:0] pixOf(input int kind, input int i);
      case (kind)
         0:       return 8'hFF;
         1:       return (i % 2 == 0) ? 8'd200 : 8'd10;
         default: return (i == 0) ? 8'd127 : ((i == 1) ? 8'd128 : 8'd0);
      endcase
   endfunction

   function automatic logic [7:0] expByte(input int kind, input logic [7:0] thr, input int j);
      logic [7:0] v;
      v = 8'h00;
      for (int b = 0; b < 8; b++) begin
         v = {v[6:0], (pixOf(kind, 8 * j + b) >= thr)};
      end
      return v;
   endfunction

   function automatic int expOnes(input int v);
`ifdef LGN_PACKER_STATS_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic clearMon();
      got.delete();
      doneCnt      = 0;
      doneWithByte = 0;
      bytesAtDone  = 0;
      errAtDone    = 0;
      firstByteNeg = -1;
      acc7Neg      = -1;
      accIdx       = 0;
      multiHigh    = 0;
      busyMid      = 0;
   endtask

   // Inputs change 1 time unit after the active edge; toggle inserts one idle cycle per pixel.
   task automatic applyStimulus(input int kind, input logic [7:0] thrA, input logic [7:0] thrB,
                                input int chgIdx, input int count, input int lastIdx, input bit toggle);
      clearMon();
      for (int i = 0; i < count; i++) begin
         @(posedge clk);
         #1;
         pif.pix_valid = 1'b1;
         pif.pix_data  = pixOf(kind, i);
         pif.pix_last  = (i == lastIdx);
         threshold     = (i >= chgIdx) ? thrB : thrA;
         if (toggle) begin
            @(posedge clk);
            #1;
            pif.pix_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      pif.pix_valid = 1'b0;
      pif.pix_last  = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkFrame(input string tag, input int kind, input logic [7:0] thr, input int nBytes,
                             input int expDone, input int expErr, input int expOnesVal);
      checkOutput({tag, " byte count"}, got.size(), nBytes);
      for (int j = 0; j < got.size() && j < nBytes; j++) begin
         checkOutput($sformatf("%s byte %0d", tag, j), got[j], expByte(kind, thr, j));
      end
      checkOutput({tag, " frame_done count"}, doneCnt, expDone);
      if (expDone != 0) begin
         checkOutput({tag, " byte_valid with frame_done"}, doneWithByte, 1);
         checkOutput({tag, " bytes at frame_done"}, bytesAtDone, nBytes);
         checkOutput({tag, " frame_error at frame_done"}, errAtDone, expErr);
         checkOutput({tag, " ones_count at frame_done"}, onesAtDone, expOnesVal);
      end
      checkOutput({tag, " frame_error after"}, frame_error, expErr);
      checkOutput({tag, " ones_count after"}, ones_count, expOnesVal);
      checkOutput({tag, " busy after"}, busy, 0);
      checkOutput({tag, " byte_valid single cycle"}, multiHigh, 0);
   endtask

   initial begin
      rst           = 1'b1;
      threshold     = 8'd0;
      pif.pix_valid = 1'b0;
      pif.pix_data  = 8'd0;
      pif.pix_last  = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset byte_valid", byte_valid, 0);
      checkOutput("reset byte_data", byte_data, 0);
      checkOutput("reset frame_done", frame_done, 0);
      checkOutput("reset frame_error", frame_error, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset ones_count", ones_count, 0);
      checkOutput("reset pix_ready", pif.pix_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post-reset pix_ready", pif.pix_ready, 1);
      checkOutput("post-reset busy", busy, 0);

      $display("[TB] frame A: all 0xFF, thr 128");
      applyStimulus(0, 8'd128, 8'd128, PIXELS, PIXELS, PIXELS - 1, 1'b0);
      checkFrame("A", 0, 8'd128, NBYTES, 1, 0, expOnes(784));
      checkOutput("A byte0 all ones", got.size() > 0 ? got[0] : 8'h00, 8'hFF);
      checkOutput("A first byte latency", firstByteNeg, acc7Neg + 1);
      checkOutput("A busy mid-frame", busyMid, 1);

      $display("[TB] frame B: alternating 200/10, continuous");
      applyStimulus(1, 8'd128, 8'd128, PIXELS, PIXELS, PIXELS - 1, 1'b0);
      checkFrame("B", 1, 8'd128, NBYTES, 1, 0, expOnes(392));
      checkOutput("B byte0 0xAA", got.size() > 0 ? got[0] : 8'h00, 8'hAA);

      $display("[TB] frame C: alternating 200/10, pix_valid toggling");
      applyStimulus(1, 8'd128, 8'd128, PIXELS, PIXELS, PIXELS - 1, 1'b1);
      checkFrame("C", 1, 8'd128, NBYTES, 1, 0, expOnes(392));

      $display("[TB] frame D: 127/128 boundary, threshold drops to 0 at px 50");
      applyStimulus(2, 8'd128, 8'd0, 50, PIXELS, PIXELS - 1, 1'b0);
      checkFrame("D", 2, 8'd128, NBYTES, 1, 0, expOnes(1));
      checkOutput("D byte0 0x40", got.size() > 0 ? got[0] : 8'h00, 8'h40);
      checkOutput("D byte97 0x00", got.size() == NBYTES ? got[NBYTES - 1] : 8'hEE, 8'h00);

      $display("[TB] frame E: pix_last on px 100");
      applyStimulus(1, 8'd128, 8'd128, PIXELS, 101, 100, 1'b0);
      checkFrame("E", 1, 8'd128, 12, 0, 1, expOnes(1));
      checkOutput("E pix_ready after abort", pif.pix_ready, 1);

      $display("[TB] frame F: clean frame after abort");
      applyStimulus(1, 8'd128, 8'd128, PIXELS, PIXELS, PIXELS - 1, 1'b0);
      checkFrame("F", 1, 8'd128, NBYTES, 1, 0, expOnes(392));

      $display("[TB] frame G: reset after px 300");
      applyStimulus(1, 8'd128, 8'd128, PIXELS, 300, -1, 1'b0);
      checkOutput("G bytes before reset", got.size(), 37);
      checkOutput("G busy before reset", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clearMon();
      repeat (20) @(posedge clk);
      @(negedge clk);
      checkOutput("G bytes after reset", got.size(), 0);
      checkOutput("G busy after reset", busy, 0);
      checkOutput("G frame_done after reset", doneCnt, 0);
      checkOutput("G ones_count after reset", ones_count, 0);

      $display("[TB] frame H: full frame after reset");
      applyStimulus(1, 8'd128, 8'd128, PIXELS, PIXELS, PIXELS - 1, 1'b0);
      checkFrame("H", 1, 8'd128, NBYTES, 1, 0, expOnes(392));

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
